temporizador_regressivo_mmss: RTL and testbench
===============================================

# temporizador_regressivo_mmss

BCD MM:SS countdown timer: the decrementing counterpart to the team's up-counting, 74163-style digit counters used in the clock datapath. Loads a preset time of up to 99:59 and decrements once per `tick` pulse. Stops at 00:00 and flags completion with a one-cycle `fim` pulse. Sits beside the up-counting clock chain, fed by the same one-per-second tick, and drives the same 4-digit display path.

## Interface
- No parameters; digit limits are fixed constants (see Structure).
- `clock`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; clears timer.
- `carregar`  in  1  load preset from `dados`.
- `dados`  in  16  preset, BCD `{min_dez, min_uni, seg_dez, seg_uni}`, 4 bits each.
- `iniciar`  in  1  start or resume counting.
- `pausar`  in  1  freeze counting.
- `tick`  in  1  one-cycle enable pulse, nominally 1 Hz.
- `Q`  out  16  current time, same BCD packing as `dados`.
- `contando`  out  1  high while in state CONTANDO.
- `fim`  out  1  one-cycle pulse when the count reaches 00:00.

## Operation
- Reset values:
  - `Q` = 16'h0000
  - `contando` = 0
  - `fim` = 0
  - state = OCIOSO
- Reset has priority over every other input.
- States: OCIOSO, CONTANDO, PAUSADO, FIM.
- OCIOSO:
  - `carregar` loads `Q` from `dados`, with clamping: `seg_uni`, `min_uni`, `min_dez` >9 become 9; `seg_dez` >5 becomes 5.
  - `iniciar` with `Q`≠0 moves to CONTANDO.
  - `iniciar` with `Q`=0 is ignored.
  - `carregar` and `iniciar` asserted together: load wins; stay in OCIOSO.
- CONTANDO:
  - `pausar` moves to PAUSADO. It has priority over a same-cycle `tick`, and that tick is dropped.
  - `tick` decrements `Q` by one second.
  - If that decrement reaches 00:00, the next state is FIM.
  - `carregar` and `iniciar` are ignored.
- PAUSADO:
  - `Q` is held.
  - `iniciar` returns to CONTANDO.
  - `carregar` loads with clamping and moves to OCIOSO.
  - `tick` is ignored.
- FIM:
  - Lasts exactly one cycle, then goes to OCIOSO unconditionally.
  - All inputs except `reset` are ignored in this cycle.
- Decrement and borrow rules:
  - `seg_uni` counts 0→9, borrowing from `seg_dez`.
  - `seg_dez` counts 0→5, borrowing from `min_uni`.
  - `min_uni` counts 0→9, borrowing from `min_dez`.
  - `min_dez` counts 0→9.
  - A digit decrements only when the tick is accepted and every lower digit is 0.
  - 00:00 is never decremented (no wrap to 99:59).
- Outputs are registered state decodes: `contando` = (state==CONTANDO), `fim` = (state==FIM).

## Timing
- The `tick` accepted at edge N updates `Q` at edge N; there is no extra pipeline stage.
- Terminal tick (00:01→00:00) at edge N:
  - state = FIM and `fim` = 1 during cycle N..N+1.
  - OCIOSO and `fim` = 0 after edge N+1.
- A load at edge N is visible on `Q` after edge N.
- `iniciar` at edge N: `contando` = 1 after edge N. A `tick` in the same cycle as `iniciar` is not counted; counting starts with the next tick.
- `reset` asserted mid-count: `Q` = 0000 and state = OCIOSO after that edge; no `fim` pulse.
- Consecutive `tick` pulses on back-to-back cycles are each counted.

## Structure
- Shared package holds:
  - State encoding (2 bits): OCIOSO=0, CONTANDO=1, PAUSADO=2, FIM=3.
  - Digit limits `LIM_UNI`=9 and `LIM_DEZ_SEG`=5.
  - BCD field offsets within the 16-bit word.
- One sub-module, `contador_decrescente_bcd`, instantiated four times:
  - Parameter `MAX`: value reloaded on borrow and used as the clamp limit.
  - Ports: `clock`, `reset`, `ld`, `en`, `D[3:0]`, `Q[3:0]`, `rco`.
  - `rco` = `en` && (`Q`==0), combinational. It is the borrow request to the next digit.
- The top level contains the FSM, clamp logic, the borrow/enable chain, and the zero detect.

## Test plan
- Reset, then load 16'h0003, `iniciar`, 3 ticks → `Q` goes 0002, 0001, 0000; `fim` high for exactly the one cycle after the third tick; `contando` 0 after that cycle.
- Load 16'h1000 (10:00), start, 1 tick → `Q`=16'h0959; 60 more ticks → `Q`=16'h0859.
- Load 16'hF7AB → `Q`=16'h9759 (clamping); `iniciar` with `Q`=0000 → `contando` stays 0.
- Counting 00:05: `pausar` and `tick` in the same cycle → `Q` unchanged, state PAUSADO. Further ticks ignored. `iniciar`, then 1 tick → `Q`=0004.
- Counting 00:02: assert `reset` together with a `tick` → `Q`=0000, `contando`=0, `fim` never asserts.
- Counting: `carregar` with `dados`=16'h0030 is ignored. In PAUSADO, the same `carregar` loads 0030 and the state becomes OCIOSO.

Source files
------------

// File: rtl/temporizador_regressivo_mmss_pkg.sv
// Shared constants for the MM:SS countdown timer: state encoding, digit limits,
// BCD field offsets and the per-digit clamp used on load.
package temporizador_regressivo_mmss_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONTANDO = 2'd1,
    PAUSADO  = 2'd2,
    FIM      = 2'd3
  } estado_t;

  localparam logic [3:0] LIM_UNI     = 4'd9;
  localparam logic [3:0] LIM_DEZ_SEG = 4'd5;

  localparam int SEG_UNI_LSB = 0;
  localparam int SEG_DEZ_LSB = 4;
  localparam int MIN_UNI_LSB = 8;
  localparam int MIN_DEZ_LSB = 12;

  function automatic logic [3:0] satura(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/contador_decrescente_bcd.sv
// One BCD digit counting down; reloads MAX on borrow, rco requests a borrow upstream.
module contador_decrescente_bcd #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ld,
  input  logic       en,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       rco
);

  assign rco = en && (Q == 4'd0);

  always_ff @(posedge clock) begin
    if (reset)   Q <= 4'd0;
    else if (ld) Q <= D;
    else if (en) Q <= (Q == 4'd0) ? MAX : Q - 4'd1;
  end

endmodule

// File: rtl/temporizador_regressivo_mmss.sv
// MM:SS countdown timer: load preset, count down on tick, one-cycle fim at 00:00.
module temporizador_regressivo_mmss
  import temporizador_regressivo_mmss_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        carregar,
  input  logic [15:0] dados,
  input  logic        iniciar,
  input  logic        pausar,
  input  logic        tick,
  output logic [15:0] Q,
  output logic        contando,
  output logic        fim
);

  estado_t     estado;
  logic [15:0] dados_sat;
  logic [4:0]  en;
  logic [3:0]  rco;
  logic        zero, aceita, ld, terminal;

  assign dados_sat[SEG_UNI_LSB +: 4] = satura(dados[SEG_UNI_LSB +: 4], LIM_UNI);
  assign dados_sat[SEG_DEZ_LSB +: 4] = satura(dados[SEG_DEZ_LSB +: 4], LIM_DEZ_SEG);
  assign dados_sat[MIN_UNI_LSB +: 4] = satura(dados[MIN_UNI_LSB +: 4], LIM_UNI);
  assign dados_sat[MIN_DEZ_LSB +: 4] = satura(dados[MIN_DEZ_LSB +: 4], LIM_UNI);

  assign zero   = (Q == 16'h0000);
  assign ld     = carregar && (estado == OCIOSO || estado == PAUSADO);
  // pausar wins over a same-cycle tick; 00:00 is never decremented
  assign aceita = (estado == CONTANDO) && tick && !pausar && !zero;

  assign en[0] = aceita;
  for (genvar i = 0; i < 4; i++) begin : g_dig
    localparam logic [3:0] LIM = (i == 1) ? LIM_DEZ_SEG : LIM_UNI;
    assign en[i+1] = rco[i];
    contador_decrescente_bcd #(.MAX(LIM)) u_dig (
      .clock (clock),
      .reset (reset),
      .ld    (ld),
      .en    (en[i]),
      .D     (dados_sat[4*i +: 4]),
      .Q     (Q[4*i +: 4]),
      .rco   (rco[i])
    );
  end

  // A borrow out of the top digit can only mean the count is exhausted
  assign terminal = aceita && ((Q == 16'h0001) || en[4]);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= OCIOSO;
      contando <= 1'b0;
      fim      <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          fim <= 1'b0;
          if (!carregar && iniciar && !zero) begin
            estado   <= CONTANDO;
            contando <= 1'b1;
          end
        end
        CONTANDO: begin
          if (pausar) begin
            estado   <= PAUSADO;
            contando <= 1'b0;
          end else if (terminal) begin
            estado   <= FIM;
            contando <= 1'b0;
            fim      <= 1'b1;
          end
        end
        PAUSADO: begin
          if (carregar) begin
            estado <= OCIOSO;
          end else if (iniciar) begin
            estado   <= CONTANDO;
            contando <= 1'b1;
          end
        end
        default: begin
          estado   <= OCIOSO;
          contando <= 1'b0;
          fim      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temporizador_regressivo_mmss.sv
// Directed stimulus pushes expected {Q, contando, fim} per cycle; a monitor pops and compares.
module tb_temporizador_regressivo_mmss;

  logic        clock = 1'b0;
  logic        reset = 1'b0, carregar = 1'b0, iniciar = 1'b0, pausar = 1'b0, tick = 1'b0;
  logic [15:0] dados = 16'h0000;
  logic [15:0] Q;
  logic        contando, fim;

  typedef struct {
    logic [15:0] q;
    logic        c;
    logic        f;
    string       nome;
  } esp_t;

  esp_t esperado[$];
  int   total = 0, passou = 0;

  always #5 clock = ~clock;

  temporizador_regressivo_mmss dut (
    .clock(clock), .reset(reset), .carregar(carregar), .dados(dados),
    .iniciar(iniciar), .pausar(pausar), .tick(tick),
    .Q(Q), .contando(contando), .fim(fim)
  );

  // Monitor: outputs are stable mid-cycle, one expectation per cycle
  always @(negedge clock) begin
    if (esperado.size() > 0) begin
      esp_t e;
      e = esperado.pop_front();
      total++;
      if (Q === e.q && contando === e.c && fim === e.f) passou++;
      else $display("FAIL %s: got Q=%h contando=%b fim=%b, expected Q=%h contando=%b fim=%b",
                    e.nome, Q, contando, fim, e.q, e.c, e.f);
    end
  end

  task automatic passo(input logic r, input logic c, input logic [15:0] d,
                       input logic i, input logic p, input logic t,
                       input logic chk, input logic [15:0] eq, input logic ec,
                       input logic ef, input string nome);
    esp_t e;
    reset = r; carregar = c; dados = d; iniciar = i; pausar = p; tick = t;
    @(posedge clock);
    if (chk) begin
      e.q = eq; e.c = ec; e.f = ef; e.nome = nome;
      esperado.push_back(e);
    end
    @(negedge clock);
    reset = 0; carregar = 0; iniciar = 0; pausar = 0; tick = 0;
  endtask

  initial begin
    @(negedge clock);
    //     rst car dados     ini pau tck chk  Q         c  f
    passo(1, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 0, "reset");
    passo(0, 1, 16'h0003, 0, 0, 0, 1, 16'h0003, 0, 0, "load0003");
    passo(0, 0, 16'h0000, 1, 0, 0, 1, 16'h0003, 1, 0, "start0003");
    passo(0, 0, 16'h0000, 0, 0, 1, 1, 16'h0002, 1, 0, "tick1");
    passo(0, 0, 16'h0000, 0, 0, 1, 1, 16'h0001, 1, 0, "tick2");
    passo(0, 0, 16'h0000, 0, 0, 1, 1, 16'h0000, 0, 1, "tick3_fim");
    passo(0, 0, 16'h0000, 1, 0, 1, 1, 16'h0000, 0, 0, "after_fim");

    passo(0, 1, 16'h1000, 0, 0, 0, 1, 16'h1000, 0, 0, "load1000");
    passo(0, 0, 16'h0000, 1, 0, 0, 1, 16'h1000, 1, 0, "start1000");
    passo(0, 0, 16'h0000, 0, 0, 1, 1, 16'h0959, 1, 0, "borrow0959");
    for (int k = 0; k < 59; k++)
      passo(0, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, "");
    passo(0, 0, 16'h0000, 0, 0, 1, 1, 16'h0859, 1, 0, "sixty_ticks0859");

    passo(0, 0, 16'h0000, 0, 1, 0, 1, 16'h0859, 0, 0, "pause0859");
    passo(0, 1, 16'hF7AB, 0, 0, 0, 1, 16'h9759, 0, 0, "clampF7AB");
    passo(0, 1, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 0, "load0000");
    passo(0, 0, 16'h0000, 1, 0, 0, 1, 16'h0000, 0, 0, "start_zero_ignored");
    passo(0, 1, 16'h0100, 1, 0, 0, 1, 16'h0100, 0, 0, "load_beats_start");
    passo(0, 0, 16'h0000, 1, 0, 0, 1, 16'h0100, 1, 0, "start0100");
    passo(0, 0, 16'h0000, 0, 0, 1, 1, 16'h0059, 1, 0, "borrow0059");

    passo(0, 0, 16'h0000, 0, 1, 0, 1, 16'h0059, 0, 0, "pause0059");
    passo(0, 1, 16'h0005, 0, 0, 0, 1, 16'h0005, 0, 0, "load0005");
    passo(0, 0, 16'h0000, 1, 0, 1, 1, 16'h0005, 1, 0, "start_tick_dropped");
    passo(0, 0, 16'h0000, 0, 1, 1, 1, 16'h0005, 0, 0, "pause_beats_tick");
    passo(0, 0, 16'h0000, 0, 0, 1, 1, 16'h0005, 0, 0, "paused_tick_ignored");
    passo(0, 0, 16'h0000, 1, 0, 0, 1, 16'h0005, 1, 0, "resume");
    passo(0, 0, 16'h0000, 0, 0, 1, 1, 16'h0004, 1, 0, "resume_tick0004");

    passo(0, 1, 16'h0030, 1, 0, 0, 1, 16'h0004, 1, 0, "load_ignored_counting");
    passo(0, 0, 16'h0000, 0, 1, 0, 1, 16'h0004, 0, 0, "pause0004");
    passo(0, 1, 16'h0030, 0, 0, 0, 1, 16'h0030, 0, 0, "paused_load0030");
    passo(0, 0, 16'h0000, 0, 0, 1, 1, 16'h0030, 0, 0, "idle_tick_ignored");
    passo(0, 1, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 0, "load0000_idle");
    passo(0, 0, 16'h0000, 1, 0, 0, 1, 16'h0000, 0, 0, "idle_start_zero");

    passo(0, 1, 16'h0002, 0, 0, 0, 1, 16'h0002, 0, 0, "load0002");
    passo(0, 0, 16'h0000, 1, 0, 0, 1, 16'h0002, 1, 0, "start0002");
    passo(1, 0, 16'h0000, 0, 0, 1, 1, 16'h0000, 0, 0, "reset_beats_tick");
    passo(0, 0, 16'h0000, 0, 0, 1, 1, 16'h0000, 0, 0, "no_fim_after_reset");
    passo(0, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 0, "still_idle");

    for (int k = 0; k < 10 && esperado.size() > 0; k++) @(posedge clock);
    if (esperado.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, required 0", esperado.size());
    end
    @(posedge clock);
    $display("%0d/%0d checks passed", passou, total);
    $finish;
  end

endmodule
